// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port initiator: merges ALU results and in-order load responses into one
// registered write stream, tracks outstanding load destinations and exports a pending mask.
module regfile_wb_ctrl #(
    parameter int XLEN     = 32,
    parameter int LD_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    output logic            alu_ready,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    output logic            ld_issue_ready,
    input  logic            ld_resp_valid,
    input  logic [XLEN-1:0] ld_resp_data,
    output logic            reg_wr,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    output logic [31:0]     pending,
    output logic            resp_err
);

    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

    logic [4:0]      rd_mem_q [LD_DEPTH];
    logic [4:0]      rd_mem_d [LD_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   scan_idx_s;
    logic [CW-1:0]   count_q, count_d;
    logic            reg_wr_q, reg_wr_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [31:0]     pending_q, pending_d;
    logic            resp_err_q, resp_err_d;
    logic            full_s, empty_s, pop_s, push_s, alu_acc_s;
    logic [4:0]      head_rd_s;

    assign full_s         = (count_q == DEPTH_C);
    assign empty_s        = (count_q == {CW{1'b0}});
    assign head_rd_s      = rd_mem_q[rd_ptr_q];
    assign pop_s          = ld_resp_valid & ~empty_s;
    // A pop in the same cycle frees the slot, so an issue while full is still taken then.
    assign push_s         = ld_issue & (~full_s | pop_s);
    assign alu_ready      = ~ld_resp_valid & ~(pending_q[alu_rd] & (alu_rd != 5'd0));
    assign alu_acc_s      = alu_valid & alu_ready;
    assign ld_issue_ready = ~full_s;

    // Load-destination FIFO next state.
    always_comb begin
        rd_mem_d = rd_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            rd_mem_d[wr_ptr_q] = ld_issue_rd;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pending mask over the FIFO contents as they will be after this cycle.
    always_comb begin
        pending_d  = 32'd0;
        scan_idx_s = rd_ptr_d;
        for (int k = 0; k < LD_DEPTH; k++) begin
            scan_idx_s = rd_ptr_d + PW'(k);
            pending_d[rd_mem_d[scan_idx_s]] = pending_d[rd_mem_d[scan_idx_s]] | (CW'(k) < count_d);
        end
        pending_d[0] = 1'b0;
    end

    // Write-stage select: load response first, then ALU; x0 writes are consumed silently.
    always_comb begin
        reg_wr_d   = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        resp_err_d = resp_err_q | (ld_resp_valid & empty_s);
        if (pop_s) begin
            waddr_d  = head_rd_s;
            wdata_d  = ld_resp_data;
            reg_wr_d = (head_rd_s != 5'd0);
        end else if (alu_acc_s) begin
            waddr_d  = alu_rd;
            wdata_d  = alu_result;
            reg_wr_d = (alu_rd != 5'd0);
        end else begin
            reg_wr_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                rd_mem_q[i] <= 5'd0;
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            reg_wr_q   <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= {XLEN{1'b0}};
            pending_q  <= 32'd0;
            resp_err_q <= 1'b0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reg_wr_q   <= reg_wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            pending_q  <= pending_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign reg_wr   = reg_wr_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign pending  = pending_q;
    assign resp_err = resp_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional mid-stream resets.
module tb_regfile_wb_ctrl;
    localparam int XLEN = 32;
    localparam int D    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            alu_ready;
    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic            ld_issue_ready;
    logic            ld_resp_valid;
    logic [XLEN-1:0] ld_resp_data;
    logic            reg_wr;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [31:0]     pending;
    logic            resp_err;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.XLEN(XLEN), .LD_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .pending(pending), .resp_err(resp_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding load destinations in issue order plus expected write outputs.
    logic [4:0]  mq[$];
    logic        m_wr;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_err;
    logic        m_alu_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = 32'd0;
        foreach (mq[i]) p[mq[i]] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    function automatic logic m_alu_ready();
        logic [31:0] p;
        p = m_pending();
        return !ld_resp_valid && !(p[alu_rd] && alu_rd != 5'd0);
    endfunction

    task automatic model_step();
        logic [4:0] rd;
        m_alu_acc = alu_valid && m_alu_ready();
        m_wr = 1'b0;
        if (ld_resp_valid) begin
            if (mq.size() > 0) begin
                rd      = mq.pop_front();
                m_waddr = rd;
                m_wdata = ld_resp_data;
                m_wr    = (rd != 5'd0);
            end else begin
                m_err = 1'b1;
            end
        end else if (m_alu_acc) begin
            m_waddr = alu_rd;
            m_wdata = alu_result;
            m_wr    = (alu_rd != 5'd0);
        end
        if (ld_issue && mq.size() < D) mq.push_back(ld_issue_rd);
    endtask

    // One clock: check handshakes, advance the model, check registered outputs after the edge.
    task automatic cycle();
        #1;
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, m_alu_ready()});
        chk("ld_issue_ready", {31'd0, ld_issue_ready}, {31'd0, (mq.size() < D)});
        model_step();
        @(posedge clk);
        #1;
        chk("reg_wr", {31'd0, reg_wr}, {31'd0, m_wr});
        chk("waddr", {27'd0, waddr}, {27'd0, m_waddr});
        chk("wdata", wdata, m_wdata);
        chk("pending", pending, m_pending());
        chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_result = 32'd0;
        ld_issue = 1'b0; ld_issue_rd = 5'd0;
        ld_resp_valid = 1'b0; ld_resp_data = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        mq.delete();
        m_wr = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_err = 1'b0;
        #1;
        chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_issue_ready", {31'd0, ld_issue_ready}, 32'd1);
        chk("rst_waddr", {27'd0, waddr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd);
        ld_issue = 1'b1; ld_issue_rd = rd;
        cycle();
        ld_issue = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        ld_resp_valid = 1'b1; ld_resp_data = data;
        cycle();
        ld_resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // ALU path, including a write to x0
        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
        cycle();
        chk("t2_wr", {31'd0, reg_wr}, 32'd1);
        chk("t2_waddr", {27'd0, waddr}, 32'd5);
        chk("t2_wdata", wdata, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_result = 32'h12345678;
        #1;
        chk("t2_x0_ready", {31'd0, alu_ready}, 32'd1);
        cycle();
        chk("t2_x0_wr", {31'd0, reg_wr}, 32'd0);
        alu_valid = 1'b0;

        // In-order load retirement
        issue(5'd3);
        chk("t3_pend_a", pending, 32'h08);
        issue(5'd7);
        chk("t3_pend_b", pending, 32'h88);
        respond(32'h11);
        chk("t3_w1", {reg_wr, 26'd0, waddr}, {1'b1, 26'd0, 5'd3});
        chk("t3_d1", wdata, 32'h11);
        chk("t3_pend_c", pending, 32'h80);
        respond(32'h22);
        chk("t3_w2", {reg_wr, 26'd0, waddr}, {1'b1, 26'd0, 5'd7});
        chk("t3_d2", wdata, 32'h22);
        chk("t3_pend_d", pending, 32'h0);

        // Load response and ALU in the same cycle
        issue(5'd4);
        alu_valid = 1'b1; alu_rd = 5'd6; alu_result = 32'h66;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h44;
        #1;
        chk("t4_alu_blocked", {31'd0, alu_ready}, 32'd0);
        cycle();
        chk("t4_ld_first", {27'd0, waddr}, 32'd4);
        chk("t4_ld_data", wdata, 32'h44);
        ld_resp_valid = 1'b0;
        cycle();
        chk("t4_alu_next", {reg_wr, 26'd0, waddr}, {1'b1, 26'd0, 5'd6});
        chk("t4_alu_data", wdata, 32'h66);
        alu_valid = 1'b0;

        // Write-after-write stall
        issue(5'd9);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall", {31'd0, alu_ready}, 32'd0);
            cycle();
            chk("t5_no_wr", {31'd0, reg_wr}, 32'd0);
        end
        respond(32'h55);
        chk("t5_ld", {27'd0, waddr, wdata[7:0]}, {27'd0, 5'd9, 8'h55});
        #1;
        chk("t5_release", {31'd0, alu_ready}, 32'd1);
        cycle();
        chk("t5_final", wdata, 32'h99);
        chk("t5_final_addr", {reg_wr, 26'd0, waddr}, {1'b1, 26'd0, 5'd9});
        alu_valid = 1'b0;

        // Full FIFO, issue+response while full, drain, then a stray response
        for (int i = 1; i <= 4; i++) issue(5'(i));
        chk("t6_full", {31'd0, ld_issue_ready}, 32'd0);
        ld_issue = 1'b1; ld_issue_rd = 5'd5;
        respond(32'hA1);
        ld_issue = 1'b0;
        chk("t6_swap_addr", {27'd0, waddr}, 32'd1);
        chk("t6_swap_pend", pending, 32'h3C);
        chk("t6_still_full", {31'd0, ld_issue_ready}, 32'd0);
        for (int i = 0; i < 4; i++) respond(32'hB0 + 32'(i));
        chk("t6_drained", pending, 32'd0);
        respond(32'hEE);
        chk("t6_err", {31'd0, resp_err}, 32'd1);
        chk("t6_no_wr", {31'd0, reg_wr}, 32'd0);

        // Reset with three loads outstanding
        issue(5'd10);
        issue(5'd11);
        issue(5'd12);
        chk("t1_pend", pending, 32'h1C00);
        do_reset();

        // Randomized traffic
        alu_valid = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!alu_valid || m_alu_acc) begin
                alu_valid  = ($urandom_range(0, 1) == 1);
                alu_rd     = 5'($urandom_range(0, 15));
                alu_result = $urandom;
            end
            ld_issue      = ($urandom_range(0, 2) == 0);
            ld_issue_rd   = 5'($urandom_range(0, 15));
            ld_resp_valid = (mq.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            ld_resp_data  = $urandom;
            cycle();
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                m_alu_acc = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
